// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the programmable sync FIFO.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Legal configuration: at least two entries and 0 <= ae < af <= depth.
    function automatic bit thresh_ok(input int depth, input int ae, input int af);
        return (depth >= 2) && (ae >= 0) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with any depth, optional FWFT read, programmable
// almost flags, sticky overflow/underflow and synchronous flush.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    flush,
    input  logic                    clr_err,
    input  logic                    wren,
    input  logic [DATA_W-1:0]       write_data,
    input  logic                    ren,
    output logic [DATA_W-1:0]       read_data,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   room_avail,
    output logic [clog2(DEPTH):0]   data_avail,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    if (!thresh_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_cfg
        $error("sync_fifo_prog: need DEPTH>=2 and 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_room;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_ovf;
    logic              r_unf;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_rej;
    logic              w_rd_rej;
    logic [DATA_W-1:0] w_ram_rdata;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Flush overrides both requests, so neither an access nor a refusal is seen.
    assign w_wr_acc = wren && !r_full  && !flush;
    assign w_rd_acc = ren  && !r_empty && !flush;
    assign w_wr_rej = wren &&  r_full  && !flush;
    assign w_rd_rej = ren  &&  r_empty && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush)                      w_count_nxt = '0;
        else if (w_wr_acc && !w_rd_acc) w_count_nxt = r_count + 1'b1;
        else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_room   <= DEPTH_C;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_room   <= DEPTH_C - w_count_nxt;
            r_full   <= (w_count_nxt == DEPTH_C);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= AF_C);
            r_aempty <= (w_count_nxt <= AE_C);
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_rd_acc) r_rd_ptr <= ptr_inc(r_rd_ptr);
                // A new refusal beats a simultaneous clear.
                if (w_wr_rej)     r_ovf <= 1'b1;
                else if (clr_err) r_ovf <= 1'b0;
                if (w_rd_rej)     r_unf <= 1'b1;
                else if (clr_err) r_unf <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (write_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head entry shown directly; forced to zero while empty so reset reads 0.
        assign read_data = r_empty ? '0 : w_ram_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] r_rdata;
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb)         r_rdata <= '0;
            else if (w_rd_acc) r_rdata <= w_ram_rdata;
        end
        assign read_data = r_rdata;
    end

    assign fifo_full    = r_full;
    assign fifo_empty   = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign room_avail   = r_room;
    assign data_avail   = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: 16-deep standard, 10-deep standard, 16-deep FWFT.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb;
    int   checks = 0;
    int   errors = 0;

    logic        a_flush, a_clr, a_wren, a_ren;
    logic [31:0] a_wdata, a_rdata;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0]  a_room, a_avail;

    logic        b_flush, b_clr, b_wren, b_ren;
    logic [31:0] b_wdata, b_rdata;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [4:0]  b_room, b_avail;

    logic        c_flush, c_clr, c_wren, c_ren;
    logic [31:0] c_wdata, c_rdata;
    logic        c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
    logic [4:0]  c_room, c_avail;

    logic [31:0] exp_q[$];

    sync_fifo_prog #(.DATA_W(32), .DEPTH(16), .FWFT(0)) dut_a (
        .clk(clk), .rstb(rstb), .flush(a_flush), .clr_err(a_clr),
        .wren(a_wren), .write_data(a_wdata), .ren(a_ren), .read_data(a_rdata),
        .fifo_full(a_full), .fifo_empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .room_avail(a_room), .data_avail(a_avail),
        .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo_prog #(.DATA_W(32), .DEPTH(10), .FWFT(0)) dut_b (
        .clk(clk), .rstb(rstb), .flush(b_flush), .clr_err(b_clr),
        .wren(b_wren), .write_data(b_wdata), .ren(b_ren), .read_data(b_rdata),
        .fifo_full(b_full), .fifo_empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .room_avail(b_room), .data_avail(b_avail),
        .overflow(b_ovf), .underflow(b_unf)
    );

    sync_fifo_prog #(.DATA_W(32), .DEPTH(16), .FWFT(1)) dut_c (
        .clk(clk), .rstb(rstb), .flush(c_flush), .clr_err(c_clr),
        .wren(c_wren), .write_data(c_wdata), .ren(c_ren), .read_data(c_rdata),
        .fifo_full(c_full), .fifo_empty(c_empty), .almost_full(c_af),
        .almost_empty(c_ae), .room_avail(c_room), .data_avail(c_avail),
        .overflow(c_ovf), .underflow(c_unf)
    );

    task automatic test_reset();
        rstb = 1'b0;
        {a_flush, a_clr, a_wren, a_ren} = '0; a_wdata = '0;
        {b_flush, b_clr, b_wren, b_ren} = '0; b_wdata = '0;
        {c_flush, c_clr, c_wren, c_ren} = '0; c_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_full, a_empty, a_af, a_ae, a_ovf, a_unf} !== 6'b010100) begin
            errors++; $display("FAIL reset_a_flags act=%b exp=010100", {a_full, a_empty, a_af, a_ae, a_ovf, a_unf});
        end
        checks++;
        if (a_room !== 5'd16 || a_avail !== 5'd0 || a_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_a_counts room=%0d avail=%0d rdata=%0h exp 16 0 0", a_room, a_avail, a_rdata);
        end
        checks++;
        if ({b_full, b_empty, b_af, b_ae, b_ovf, b_unf} !== 6'b010100 || b_room !== 5'd10) begin
            errors++; $display("FAIL reset_b flags=%b room=%0d exp 010100 10", {b_full, b_empty, b_af, b_ae, b_ovf, b_unf}, b_room);
        end
        checks++;
        if (c_empty !== 1'b1 || c_rdata !== 32'd0 || c_avail !== 5'd0) begin
            errors++; $display("FAIL reset_c empty=%b rdata=%0h avail=%0d exp 1 0 0", c_empty, c_rdata, c_avail);
        end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 16; i++) begin
            a_wren = 1'b1; a_wdata = 32'hA34D;
            @(negedge clk);
            checks++;
            if (a_avail !== 5'(i) || a_af !== (i >= 14) || a_full !== (i == 16) || a_ae !== (i <= 2) || a_empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d avail=%0d af=%b full=%b ae=%b empty=%b exp %0d %b %b %b 0",
                         i, a_avail, a_af, a_full, a_ae, a_empty, i, (i >= 14), (i == 16), (i <= 2));
            end
        end
        checks++;
        if (a_room !== 5'd0) begin errors++; $display("FAIL full_room act=%0d exp=0", a_room); end
        @(negedge clk);
        a_wren = 1'b0;
        checks++;
        if (a_ovf !== 1'b1 || a_avail !== 5'd16) begin
            errors++; $display("FAIL overflow ovf=%b avail=%0d exp 1 16", a_ovf, a_avail);
        end
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        checks++;
        if (a_ovf !== 1'b0 || a_avail !== 5'd16) begin
            errors++; $display("FAIL clr_err ovf=%b avail=%0d exp 0 16", a_ovf, a_avail);
        end
    endtask

    task automatic test_full_wr_rd();
        a_wren = 1'b1; a_ren = 1'b1; a_wdata = 32'h1111;
        @(negedge clk);
        a_wren = 1'b0; a_ren = 1'b0;
        checks++;
        if (a_avail !== 5'd15 || a_ovf !== 1'b1 || a_full !== 1'b0 || a_rdata !== 32'hA34D || a_room !== 5'd1) begin
            errors++;
            $display("FAIL full_wr_rd avail=%0d ovf=%b full=%b rdata=%0h room=%0d exp 15 1 0 a34d 1",
                     a_avail, a_ovf, a_full, a_rdata, a_room);
        end
    endtask

    task automatic test_flush();
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        checks++;
        if (a_avail !== 5'd0 || a_empty !== 1'b1 || a_ovf !== 1'b0 || a_room !== 5'd16) begin
            errors++; $display("FAIL flush_full avail=%0d empty=%b ovf=%b room=%0d exp 0 1 0 16", a_avail, a_empty, a_ovf, a_room);
        end
        for (int i = 0; i < 8; i++) begin
            a_wren = 1'b1; a_wdata = 32'h100 + i;
            @(negedge clk);
        end
        checks++;
        if (a_avail !== 5'd8) begin errors++; $display("FAIL flush_pre act=%0d exp=8", a_avail); end
        a_flush = 1'b1; a_wren = 1'b1; a_ren = 1'b1;
        @(negedge clk);
        a_flush = 1'b0; a_wren = 1'b0; a_ren = 1'b0;
        checks++;
        if (a_avail !== 5'd0 || a_empty !== 1'b1 || a_unf !== 1'b0 || a_ovf !== 1'b0 || a_rdata !== 32'hA34D) begin
            errors++;
            $display("FAIL flush_8 avail=%0d empty=%b unf=%b ovf=%b rdata=%0h exp 0 1 0 0 a34d",
                     a_avail, a_empty, a_unf, a_ovf, a_rdata);
        end
    endtask

    task automatic test_order_underflow();
        for (int i = 0; i < 16; i++) begin
            a_wren = 1'b1; a_wdata = i;
            @(negedge clk);
        end
        a_wren = 1'b0;
        a_ren = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (a_rdata !== 32'(i)) begin errors++; $display("FAIL order_%0d rdata=%0h exp=%0h", i, a_rdata, i); end
        end
        a_ren = 1'b0;
        checks++;
        if (a_empty !== 1'b1 || a_avail !== 5'd0 || a_ae !== 1'b1 || a_unf !== 1'b0) begin
            errors++; $display("FAIL drained empty=%b avail=%0d ae=%b unf=%b exp 1 0 1 0", a_empty, a_avail, a_ae, a_unf);
        end
        a_ren = 1'b1; a_clr = 1'b1;
        @(negedge clk);
        a_ren = 1'b0; a_clr = 1'b0;
        checks++;
        if (a_unf !== 1'b1 || a_rdata !== 32'd15 || a_avail !== 5'd0) begin
            errors++; $display("FAIL underflow unf=%b rdata=%0h avail=%0d exp 1 f 0", a_unf, a_rdata, a_avail);
        end
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        checks++;
        if (a_unf !== 1'b0) begin errors++; $display("FAIL unf_clear act=%b exp=0", a_unf); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        for (int i = 0; i < 5; i++) begin
            b_wren = 1'b1; b_wdata = 32'hB000 + i; exp_q.push_back(b_wdata);
            @(negedge clk);
        end
        for (int i = 5; i < 30; i++) begin
            b_wren = 1'b1; b_ren = 1'b1; b_wdata = 32'hB000 + i; exp_q.push_back(b_wdata);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (b_rdata !== exp || b_avail !== 5'd5) begin
                errors++; $display("FAIL wrap_%0d rdata=%0h avail=%0d exp %0h 5", i, b_rdata, b_avail, exp);
            end
        end
        b_ren = 1'b0;
        for (int i = 30; i < 36; i++) begin
            b_wdata = 32'hB000 + i;
            if (i < 35) exp_q.push_back(b_wdata);
            @(negedge clk);
        end
        b_wren = 1'b0;
        checks++;
        if (b_avail !== 5'd10 || b_full !== 1'b1 || b_room !== 5'd0 || b_ovf !== 1'b1 || b_af !== 1'b1) begin
            errors++;
            $display("FAIL b_full avail=%0d full=%b room=%0d ovf=%b af=%b exp 10 1 0 1 1", b_avail, b_full, b_room, b_ovf, b_af);
        end
        b_ren = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (b_rdata !== exp) begin errors++; $display("FAIL drain_b_%0d rdata=%0h exp=%0h", i, b_rdata, exp); end
        end
        b_ren = 1'b0;
        checks++;
        if (b_empty !== 1'b1 || b_avail !== 5'd0) begin
            errors++; $display("FAIL b_empty empty=%b avail=%0d exp 1 0", b_empty, b_avail);
        end
    endtask

    task automatic test_fwft();
        c_wren = 1'b1; c_wdata = 32'h9C7B;
        @(negedge clk);
        c_wren = 1'b0;
        checks++;
        if (c_empty !== 1'b0 || c_rdata !== 32'h9C7B || c_avail !== 5'd1) begin
            errors++; $display("FAIL fwft_show empty=%b rdata=%0h avail=%0d exp 0 9c7b 1", c_empty, c_rdata, c_avail);
        end
        c_ren = 1'b1;
        @(negedge clk);
        c_ren = 1'b0;
        checks++;
        if (c_empty !== 1'b1 || c_avail !== 5'd0) begin
            errors++; $display("FAIL fwft_pop empty=%b avail=%0d exp 1 0", c_empty, c_avail);
        end
        c_wren = 1'b1; c_ren = 1'b1; c_wdata = 32'h5A5A;
        @(negedge clk);
        c_ren = 1'b0; c_wdata = 32'h7777;
        checks++;
        if (c_avail !== 5'd1 || c_unf !== 1'b1 || c_rdata !== 32'h5A5A) begin
            errors++; $display("FAIL fwft_empty_wr_rd avail=%0d unf=%b rdata=%0h exp 1 1 5a5a", c_avail, c_unf, c_rdata);
        end
        @(negedge clk);
        c_wren = 1'b0;
        checks++;
        if (c_avail !== 5'd2 || c_rdata !== 32'h5A5A) begin
            errors++; $display("FAIL fwft_hold avail=%0d rdata=%0h exp 2 5a5a", c_avail, c_rdata);
        end
        c_ren = 1'b1;
        @(negedge clk);
        c_ren = 1'b0;
        checks++;
        if (c_avail !== 5'd1 || c_rdata !== 32'h7777) begin
            errors++; $display("FAIL fwft_next avail=%0d rdata=%0h exp 1 7777", c_avail, c_rdata);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            a_wren = 1'b1; a_wdata = 32'hC0 + i;
            @(negedge clk);
        end
        a_wren = 1'b0;
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (a_avail !== 5'd0 || a_empty !== 1'b1 || a_room !== 5'd16 || a_rdata !== 32'd0 || a_ae !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_a avail=%0d empty=%b room=%0d rdata=%0h ae=%b exp 0 1 16 0 1",
                     a_avail, a_empty, a_room, a_rdata, a_ae);
        end
        checks++;
        if (b_ovf !== 1'b0 || c_empty !== 1'b1 || c_rdata !== 32'd0 || c_unf !== 1'b0) begin
            errors++; $display("FAIL mid_reset_bc b_ovf=%b c_empty=%b c_rdata=%0h c_unf=%b exp 0 1 0 0", b_ovf, c_empty, c_rdata, c_unf);
        end
        #1 rstb = 1'b1;
        @(negedge clk);
        a_wren = 1'b1; a_wdata = 32'hBEEF;
        @(negedge clk);
        a_wren = 1'b0; a_ren = 1'b1;
        @(negedge clk);
        a_ren = 1'b0;
        checks++;
        if (a_rdata !== 32'hBEEF || a_avail !== 5'd0) begin
            errors++; $display("FAIL after_reset rdata=%0h avail=%0d exp beef 0", a_rdata, a_avail);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_wr_rd();
        test_flush();
        test_order_underflow();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO, successor to the fixed 16x32 sync FIFO. Adds:
- depth that need not be a power of two (explicit pointer wrap);
- selectable standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- synchronous flush.

It is the general buffering block between producer and consumer datapaths in the same clock domain.

Parameters:
DATA_W, 32, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer)
PTR_W, clog2(DEPTH), address width; derived, not overridden
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when data_avail >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when data_avail <= AE_THRESH

Ports:
clk  in  1  single clock, all state on rising edge
rstb  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of pointers, count and error flags
clr_err  in  1  synchronous clear of sticky error flags
wren  in  1  write request
write_data  in  DATA_W  write data
ren  in  1  read request
read_data  out  DATA_W  read data
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
room_avail  out  PTR_W+1  DEPTH - count
data_avail  out  PTR_W+1  count
overflow  out  1  sticky: a write was refused because the FIFO was full
underflow  out  1  sticky: a read was refused because the FIFO was empty

Behaviour:
- Reset (rstb low, async):
  - write_ptr = read_ptr = count = 0; read_data = 0.
  - fifo_empty = 1, almost_empty = 1; fifo_full = 0, almost_full = 0.
  - room_avail = DEPTH, data_avail = 0, overflow = underflow = 0.
  - Memory contents are not reset.
- Acceptance:
  - Write accepted iff wren && !fifo_full.
  - Read accepted iff ren && !fifo_empty.
  - Both judged on the registered flags at the start of the cycle.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. Never use a modulo-2^PTR_W wrap.
- count:
  - +1 on write-only, -1 on read-only.
  - Unchanged on simultaneous accepted read and write, or when nothing is accepted.
- Flags: all registered, derived from next-state count, so they are valid the cycle after the causing edge.
- Full with wren && ren: read accepted; write refused; overflow set; count becomes DEPTH-1.
- Empty with wren && ren: write accepted; read refused; underflow set; count becomes 1.
  - In FWFT mode the written word appears on read_data the next cycle.
- Standard mode (FWFT=0):
  - read_data <= mem[read_ptr] on an accepted read; latency 1 cycle.
  - read_data holds its value otherwise.
- FWFT mode (FWFT=1):
  - read_data shows the head entry whenever fifo_empty = 0.
  - An accepted read pops the entry; the next entry is shown the following cycle.
  - read_data is don't-care while empty.
- Sticky errors:
  - Set on the refused access; held until clr_err, flush or reset.
  - If clr_err and a new error occur in the same cycle, set wins.
- flush:
  - Highest synchronous priority: pointers and count go to 0, errors clear.
  - wren/ren in the same cycle are ignored; memory is untouched.
- Thresholds:
  - Parameter check (elaboration-time error): 0 <= AE_THRESH < AF_THRESH <= DEPTH.
- Invariant: room_avail + data_avail == DEPTH always.

Decomposition:
- Package fifo_pkg:
  - clog2 function;
  - FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1 constants;
  - the threshold-legality check macro/function.
- Sub-module fifo_ram:
  - simple dual-port register array (DEPTH x DATA_W);
  - one synchronous write port and one asynchronous read port;
  - the top-level registers the read output for standard mode.

Test Plan:
- DEPTH=16, FWFT=0: reset, write 0xA34D x16 → fifo_full=1, almost_full=1 after 14th write, room_avail=0, data_avail=16.
- Same bench: 17th wren → overflow=1, data_avail stays 16; clr_err → overflow=0.
- DEPTH=16, FWFT=0: write 0..15, then read 16 → read_data sequence 0..15, each 1 cycle after ren; fifo_empty=1; extra ren → underflow=1.
- DEPTH=10 (non-power-of-two): 25 interleaved write/read pairs → data in order; pointers wrap 9→0; data_avail never exceeds 10.
- FWFT=1, DEPTH=16: single write of 0x9C7B → read_data=0x9C7B with ren low on the cycle fifo_empty drops; ren pops → fifo_empty=1 next cycle.
- Corner cases:
  - Full with wren && ren both high → data_avail 15, overflow=1.
  - flush with 8 entries → data_avail=0, fifo_empty=1 next cycle.
  - rstb pulsed low mid-stream → all outputs at reset values immediately.
